op_dispatcher: RTL and testbench
================================

// Module: op_dispatcher
// PURPOSE
//  Sits between the gcode parser and the opcode handlers; the dummy/meta handler is index 0.
//  Accepts one decoded Op_st per valid/rdy handshake, maps its opcode to a handler index,
//  triggers that handler and waits for its done. Muxes the selected handler's motor commands
//  onto the single motors port. Watchdog aborts a handler that never signals done.
// PARAMETERS
//  NUM_HANDLERS  4      number of attached opcode handlers (index 0 = dummy/meta handler)
//  PULSE_W       16     width of pulse_num_x / pulse_num_y
//  TIMEOUT       2**20  clk_en ticks allowed in BUSY before abort; 0 disables watchdog
// PORTS
//  clk             in   1              system clock
//  reset           in   1              synchronous, active-high reset
//  clk_en          in   1              module enable tick; FSM advances only when high
//  op_valid        in   1              parser has an op on op_in
//  op_rdy          out  1              dispatcher can accept an op (combinational: state==IDLE)
//  op_in           in   Op_st          op from parser
//  h_op            out  Op_st          latched op, broadcast to all handlers
//  h_trigger       out  NUM_HANDLERS   one-hot trigger to the selected handler
//  h_rdy           in   NUM_HANDLERS   handler ready flags
//  h_done          in   NUM_HANDLERS   handler done flags
//  h_pulse_num_x   in   NUM_HANDLERS*PULSE_W  per-handler X pulse counts (packed, index 0 at LSB)
//  h_pulse_num_y   in   NUM_HANDLERS*PULSE_W  per-handler Y pulse counts
//  h_servo_pos     in   NUM_HANDLERS   per-handler servo position
//  h_motors_trig   in   NUM_HANDLERS   per-handler motors trigger
//  h_motors_done   out  NUM_HANDLERS   m_done routed to the selected handler only
//  h_motors_rdy    out  NUM_HANDLERS   m_rdy routed to the selected handler only
//  m_pulse_num_x   out  PULSE_W        to motors
//  m_pulse_num_y   out  PULSE_W        to motors
//  m_servo_pos     out  1              to motors
//  m_trigger       out  1              to motors
//  m_done, m_rdy   in   1              from motors
//  busy            out  1              state != IDLE
//  err_unknown     out  1              one-clk_en pulse: opcode had no mapping
//  err_timeout     out  1              one-clk_en pulse: watchdog abort
// BEHAVIOUR
//  Reset: state=IDLE, sel=0, h_op=0, counter=0. Outputs: op_rdy=1, busy=0, h_trigger=0,
//    errs=0, m_trigger=0, m_pulse_num_*=0, m_servo_pos=SERVO_POS_UP. Reset mid-op aborts immediately.
//  FSM (transitions only on clk_en=1):
//   IDLE:     op_valid&&op_rdy -> latch op_in into h_op; sel=opcode_to_handler(opcode) -> WAIT_RDY.
//             Unmapped opcode: sel=0, err_unknown pulses.
//   WAIT_RDY: h_rdy[sel]=1 -> TRIGGER; else hold (no timeout here).
//   TRIGGER:  h_trigger[sel]=1 for the whole state; leave after one clk_en tick -> BUSY; counter=0.
//   BUSY:     h_done[sel]=1 -> IDLE. Else counter++ ; counter==TIMEOUT-1 -> err_timeout, IDLE.
//             done and timeout on the same tick: done wins, no error.
//  clk_en=0: all state, counter and error pulses hold; no accept occurs.
//  Motors mux: in WAIT_RDY/TRIGGER/BUSY, m_* = selected handler's values and only
//    h_motors_done[sel]/h_motors_rdy[sel] follow m_done/m_rdy; others 0.
//    In IDLE m_* take reset values, all h_motors_* = 0.
//  Counter width = $clog2(TIMEOUT+1); no wrap possible (exits at TIMEOUT-1).
//  h_done from non-selected handlers is ignored.
// STRUCTURE
//  Op_PKG: HANDLER_IDX_W, handler index constants, function opcode_to_handler returning
//    {valid, idx}. Servo_PKG: SERVO_POS_UP (existing).
//  Sub-module op_dispatcher_fsm: state, sel, counter, handshake; top level holds the muxes.
// TESTING
//  1. Reset, clk_en=1 -> op_rdy=1, m_servo_pos=SERVO_POS_UP, all h_trigger=0.
//  2. Meta op (maps to 0), h_rdy=4'b0001, done 3 ticks later -> h_trigger=0001 one tick, back to IDLE.
//  3. Move op to idx 1, h_rdy[1] low 5 ticks -> stays WAIT_RDY, trigger only after h_rdy[1]=1.
//  4. TIMEOUT=8, idx 2 never done -> err_timeout on tick 8 of BUSY, IDLE, op_rdy=1.
//  5. Unmapped opcode -> err_unknown pulse, sel=0, dummy triggered; clk_en toggling 1/3 duty -> same sequence stretched.
//  6. Reset asserted in BUSY with h_motors_trig[1]=1 -> next clk m_trigger=0, IDLE.

Source files
------------

// File: rtl/op_dispatcher_pkg.sv
// Shared types and constants for the opcode dispatcher: op record, handler indices,
// opcode-to-handler mapping and servo positions.
package op_dispatcher_pkg;

   localparam int unsigned OPCODE_W      = 8;
   localparam int unsigned ARG_W         = 16;
   localparam int unsigned HANDLER_IDX_W = 2;

   localparam logic [HANDLER_IDX_W-1:0] HANDLER_META  = 2'd0;
   localparam logic [HANDLER_IDX_W-1:0] HANDLER_MOVE  = 2'd1;
   localparam logic [HANDLER_IDX_W-1:0] HANDLER_LINE  = 2'd2;
   localparam logic [HANDLER_IDX_W-1:0] HANDLER_SERVO = 2'd3;

   localparam logic [OPCODE_W-1:0] OPC_NOP      = 8'h00;
   localparam logic [OPCODE_W-1:0] OPC_HOME     = 8'h01;
   localparam logic [OPCODE_W-1:0] OPC_MOVE     = 8'h10;
   localparam logic [OPCODE_W-1:0] OPC_LINE     = 8'h11;
   localparam logic [OPCODE_W-1:0] OPC_PEN_UP   = 8'h20;
   localparam logic [OPCODE_W-1:0] OPC_PEN_DOWN = 8'h21;

   localparam logic SERVO_POS_UP   = 1'b1;
   localparam logic SERVO_POS_DOWN = 1'b0;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [ARG_W-1:0]    x;
      logic [ARG_W-1:0]    y;
      logic [ARG_W-1:0]    feed;
   } op_st_t;

   // Returns {valid, idx}; valid=0 means the opcode has no handler.
   function automatic logic [HANDLER_IDX_W:0] opcode_to_handler(
      input logic [OPCODE_W-1:0] opcode
   );
      logic [HANDLER_IDX_W:0] res;
      case (opcode)
         OPC_NOP, OPC_HOME:         res = {1'b1, HANDLER_META};
         OPC_MOVE:                  res = {1'b1, HANDLER_MOVE};
         OPC_LINE:                  res = {1'b1, HANDLER_LINE};
         OPC_PEN_UP, OPC_PEN_DOWN:  res = {1'b1, HANDLER_SERVO};
         default:                   res = {1'b0, HANDLER_META};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/op_dispatcher_fsm.sv
// Dispatcher control: accepts ops, selects a handler, triggers it and waits for done
// under a watchdog. Everything advances only on clk_en ticks.
module op_dispatcher_fsm
   import op_dispatcher_pkg::*;
#(
   parameter int unsigned NUM_HANDLERS = 4,
   parameter int unsigned TIMEOUT      = 2**20
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     clk_en_i,
   input  logic                     op_valid_i,
   input  op_st_t                   op_i,
   input  logic [NUM_HANDLERS-1:0]  h_rdy_i,
   input  logic [NUM_HANDLERS-1:0]  h_done_i,
   output logic                     op_rdy_o,
   output logic                     busy_o,
   output logic                     trigger_o,
   output op_st_t                   h_op_o,
   output logic [HANDLER_IDX_W-1:0] sel_o,
   output logic                     err_unknown_o,
   output logic                     err_timeout_o
);

   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StWaitRdy = 2'd1;
   localparam logic [1:0] StTrigger = 2'd2;
   localparam logic [1:0] StBusy    = 2'd3;

   logic [1:0]               state_q, state_d;
   logic [HANDLER_IDX_W-1:0] sel_q, sel_d;
   op_st_t                   op_q, op_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic                     err_unknown_q, err_unknown_d;
   logic                     err_timeout_q, err_timeout_d;
   logic [HANDLER_IDX_W:0]   map;

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      op_d          = op_q;
      cnt_d         = cnt_q;
      err_unknown_d = err_unknown_q;
      err_timeout_d = err_timeout_q;
      map           = opcode_to_handler(op_i.opcode);

      // Error flags are one-tick pulses; they hold while clk_en is low.
      if (clk_en_i) begin
         err_unknown_d = 1'b0;
         err_timeout_d = 1'b0;
         case (state_q)
            StIdle: begin
               if (op_valid_i) begin
                  op_d    = op_i;
                  state_d = StWaitRdy;
                  if (map[HANDLER_IDX_W] && (32'(map[HANDLER_IDX_W-1:0]) < NUM_HANDLERS)) begin
                     sel_d = map[HANDLER_IDX_W-1:0];
                  end else begin
                     sel_d         = '0;
                     err_unknown_d = 1'b1;
                  end
               end
            end
            StWaitRdy: begin
               if (h_rdy_i[sel_q]) state_d = StTrigger;
            end
            StTrigger: begin
               state_d = StBusy;
               cnt_d   = '0;
            end
            StBusy: begin
               if (h_done_i[sel_q]) begin
                  state_d = StIdle;
               end else if ((TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
                  state_d       = StIdle;
                  err_timeout_d = 1'b1;
               end else if (TIMEOUT != 0) begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         sel_q         <= '0;
         op_q          <= '0;
         cnt_q         <= '0;
         err_unknown_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         op_q          <= op_d;
         cnt_q         <= cnt_d;
         err_unknown_q <= err_unknown_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign op_rdy_o      = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign trigger_o     = (state_q == StTrigger);
   assign h_op_o        = op_q;
   assign sel_o         = sel_q;
   assign err_unknown_o = err_unknown_q;
   assign err_timeout_o = err_timeout_q;

endmodule

// File: rtl/op_dispatcher.sv
// Routes decoded ops from the parser to one of several opcode handlers and muxes the
// selected handler's motor commands onto the shared motors port.
module op_dispatcher
   import op_dispatcher_pkg::*;
#(
   parameter int unsigned NUM_HANDLERS = 4,
   parameter int unsigned PULSE_W      = 16,
   parameter int unsigned TIMEOUT      = 2**20
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            clk_en,
   input  logic                            op_valid,
   output logic                            op_rdy,
   input  op_st_t                          op_in,
   output op_st_t                          h_op,
   output logic [NUM_HANDLERS-1:0]         h_trigger,
   input  logic [NUM_HANDLERS-1:0]         h_rdy,
   input  logic [NUM_HANDLERS-1:0]         h_done,
   input  logic [NUM_HANDLERS*PULSE_W-1:0] h_pulse_num_x,
   input  logic [NUM_HANDLERS*PULSE_W-1:0] h_pulse_num_y,
   input  logic [NUM_HANDLERS-1:0]         h_servo_pos,
   input  logic [NUM_HANDLERS-1:0]         h_motors_trig,
   output logic [NUM_HANDLERS-1:0]         h_motors_done,
   output logic [NUM_HANDLERS-1:0]         h_motors_rdy,
   output logic [PULSE_W-1:0]              m_pulse_num_x,
   output logic [PULSE_W-1:0]              m_pulse_num_y,
   output logic                            m_servo_pos,
   output logic                            m_trigger,
   input  logic                            m_done,
   input  logic                            m_rdy,
   output logic                            busy,
   output logic                            err_unknown,
   output logic                            err_timeout
);

   logic [HANDLER_IDX_W-1:0] sel;
   logic                     trigger;
   logic                     active;

   op_dispatcher_fsm #(
      .NUM_HANDLERS (NUM_HANDLERS),
      .TIMEOUT      (TIMEOUT)
   ) u_fsm (
      .clk_i         (clk),
      .reset_i       (reset),
      .clk_en_i      (clk_en),
      .op_valid_i    (op_valid),
      .op_i          (op_in),
      .h_rdy_i       (h_rdy),
      .h_done_i      (h_done),
      .op_rdy_o      (op_rdy),
      .busy_o        (active),
      .trigger_o     (trigger),
      .h_op_o        (h_op),
      .sel_o         (sel),
      .err_unknown_o (err_unknown),
      .err_timeout_o (err_timeout)
   );

   assign busy = active;

   // Outside IDLE the selected handler owns the motors; in IDLE they park at reset values.
   always_comb begin
      m_pulse_num_x = '0;
      m_pulse_num_y = '0;
      m_servo_pos   = SERVO_POS_UP;
      m_trigger     = 1'b0;
      h_trigger     = '0;
      h_motors_done = '0;
      h_motors_rdy  = '0;
      for (int unsigned i = 0; i < NUM_HANDLERS; i++) begin
         if (active && (32'(sel) == i)) begin
            m_pulse_num_x    = h_pulse_num_x[i*PULSE_W +: PULSE_W];
            m_pulse_num_y    = h_pulse_num_y[i*PULSE_W +: PULSE_W];
            m_servo_pos      = h_servo_pos[i];
            m_trigger        = h_motors_trig[i];
            h_motors_done[i] = m_done;
            h_motors_rdy[i]  = m_rdy;
            h_trigger[i]     = trigger;
         end
      end
   end

endmodule

// File: tb/tb_op_dispatcher.sv
// Directed bench for op_dispatcher: handshake, handler wait, watchdog, unknown opcodes,
// clk_en stretching and mid-op reset.
module tb_op_dispatcher;
   import op_dispatcher_pkg::*;

   localparam int unsigned NH = 4;
   localparam int unsigned PW = 16;

   logic            clk = 1'b0;
   logic            reset, clk_en, op_valid, op_rdy;
   op_st_t          op_in, h_op;
   logic [NH-1:0]   h_trigger, h_rdy, h_done, h_servo_pos, h_motors_trig;
   logic [NH-1:0]   h_motors_done, h_motors_rdy;
   logic [NH*PW-1:0] h_pulse_num_x, h_pulse_num_y;
   logic [PW-1:0]   m_pulse_num_x, m_pulse_num_y;
   logic            m_servo_pos, m_trigger, m_done, m_rdy;
   logic            busy, err_unknown, err_timeout;

   int errors = 0;
   int checks = 0;

   op_dispatcher #(
      .NUM_HANDLERS (NH),
      .PULSE_W      (PW),
      .TIMEOUT      (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .clk_en        (clk_en),
      .op_valid      (op_valid),
      .op_rdy        (op_rdy),
      .op_in         (op_in),
      .h_op          (h_op),
      .h_trigger     (h_trigger),
      .h_rdy         (h_rdy),
      .h_done        (h_done),
      .h_pulse_num_x (h_pulse_num_x),
      .h_pulse_num_y (h_pulse_num_y),
      .h_servo_pos   (h_servo_pos),
      .h_motors_trig (h_motors_trig),
      .h_motors_done (h_motors_done),
      .h_motors_rdy  (h_motors_rdy),
      .m_pulse_num_x (m_pulse_num_x),
      .m_pulse_num_y (m_pulse_num_y),
      .m_servo_pos   (m_servo_pos),
      .m_trigger     (m_trigger),
      .m_done        (m_done),
      .m_rdy         (m_rdy),
      .busy          (busy),
      .err_unknown   (err_unknown),
      .err_timeout   (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic op_st_t mk_op(input logic [7:0] opc);
      op_st_t o;
      o.opcode = opc;
      o.x      = 16'h1234;
      o.y      = 16'h5678;
      o.feed   = {8'h9A, opc};
      return o;
   endfunction

   initial begin
      reset         = 1'b1;
      clk_en        = 1'b1;
      op_valid      = 1'b0;
      op_in         = '0;
      h_rdy         = '0;
      h_done        = '0;
      h_pulse_num_x = {16'h3333, 16'h2222, 16'h1111, 16'h0AAA};
      h_pulse_num_y = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
      h_servo_pos   = 4'b1010;
      h_motors_trig = '0;
      m_done        = 1'b0;
      m_rdy         = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // 1. reset state
      check("rst_op_rdy", op_rdy, 1);
      check("rst_busy", busy, 0);
      check("rst_h_trigger", h_trigger, 0);
      check("rst_servo", m_servo_pos, SERVO_POS_UP);
      check("rst_m_trigger", m_trigger, 0);
      check("rst_pulse_x", m_pulse_num_x, 0);
      check("rst_h_op", h_op, 0);
      check("rst_errs", {err_unknown, err_timeout}, 0);
      check("rst_motors_rdy", h_motors_rdy, 0);

      // 2. meta op to handler 0
      op_in    = mk_op(OPC_HOME);
      op_valid = 1'b1;
      h_rdy    = 4'b0001;
      tick();
      op_valid = 1'b0;
      check("meta_busy", busy, 1);
      check("meta_op_rdy", op_rdy, 0);
      check("meta_h_op", h_op, mk_op(OPC_HOME));
      check("meta_err_unknown", err_unknown, 0);
      check("meta_servo", m_servo_pos, 0);
      check("meta_pulse_x", m_pulse_num_x, 16'h0AAA);
      check("meta_motors_rdy", h_motors_rdy, 4'b0001);
      tick();
      check("meta_trigger", h_trigger, 4'b0001);
      tick();
      check("meta_trigger_off", h_trigger, 0);
      tick();
      tick();
      h_done = 4'b0001;
      tick();
      h_done = '0;
      check("meta_idle", busy, 0);
      check("meta_idle_rdy", op_rdy, 1);
      check("meta_idle_servo", m_servo_pos, SERVO_POS_UP);
      check("meta_idle_mrdy", h_motors_rdy, 0);

      // 3. move op, handler 1 not ready for 5 ticks
      op_in    = mk_op(OPC_MOVE);
      op_valid = 1'b1;
      h_rdy    = 4'b1101;
      tick();
      op_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("move_wait_trig", h_trigger, 0);
      end
      check("move_wait_busy", busy, 1);
      h_rdy = 4'b1111;
      tick();
      check("move_trigger", h_trigger, 4'b0010);
      check("move_pulse_x", m_pulse_num_x, 16'h1111);
      check("move_pulse_y", m_pulse_num_y, 16'hC001);
      check("move_servo", m_servo_pos, 1);
      h_motors_trig = 4'b0010;
      m_done        = 1'b1;
      #1;
      check("move_m_trigger", m_trigger, 1);
      check("move_motors_done", h_motors_done, 4'b0010);
      tick();
      h_done = 4'b1101;
      tick();
      check("move_other_done_ignored", busy, 1);
      h_done = 4'b0010;
      tick();
      h_done = '0;
      check("move_idle", busy, 0);
      check("move_idle_mtrig", m_trigger, 0);
      check("move_idle_mdone", h_motors_done, 0);
      h_motors_trig = '0;
      m_done        = 1'b0;

      // 4. line op on handler 2 never done -> watchdog on tick 8 of BUSY
      op_in    = mk_op(OPC_LINE);
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 7; k++) tick();
      check("to_busy_t7", busy, 1);
      check("to_err_t7", err_timeout, 0);
      tick();
      check("to_err_t8", err_timeout, 1);
      check("to_idle_t8", busy, 0);
      check("to_op_rdy_t8", op_rdy, 1);
      tick();
      check("to_err_clear", err_timeout, 0);

      // 4b. done on the watchdog tick wins
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 7; k++) tick();
      h_done = 4'b0100;
      tick();
      h_done = '0;
      check("tie_idle", busy, 0);
      check("tie_no_err", err_timeout, 0);

      // 5. unknown opcode with clk_en at 1/3 duty
      op_in    = mk_op(8'hEE);
      op_valid = 1'b1;
      h_rdy    = 4'b0001;
      clk_en   = 1'b0;
      tick();
      check("unk_no_accept", op_rdy, 1);
      clk_en = 1'b1;
      tick();
      op_valid = 1'b0;
      clk_en   = 1'b0;
      check("unk_err", err_unknown, 1);
      check("unk_busy", busy, 1);
      check("unk_h_op", h_op.opcode, 8'hEE);
      check("unk_sel0_pulse", m_pulse_num_x, 16'h0AAA);
      tick();
      tick();
      check("unk_err_hold", err_unknown, 1);
      check("unk_no_trig_yet", h_trigger, 0);
      clk_en = 1'b1;
      tick();
      clk_en = 1'b0;
      check("unk_err_clear", err_unknown, 0);
      check("unk_trigger", h_trigger, 4'b0001);
      tick();
      tick();
      check("unk_trigger_hold", h_trigger, 4'b0001);
      clk_en = 1'b1;
      tick();
      clk_en = 1'b0;
      check("unk_trigger_off", h_trigger, 0);
      h_done = 4'b0001;
      tick();
      check("unk_done_held", busy, 1);
      clk_en = 1'b1;
      tick();
      h_done = '0;
      check("unk_idle", op_rdy, 1);

      // 6. reset mid-op while handler 1 drives the motors
      op_in    = mk_op(OPC_MOVE);
      op_valid = 1'b1;
      h_rdy    = 4'b1111;
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      h_motors_trig = 4'b0010;
      #1;
      check("rstmid_m_trigger", m_trigger, 1);
      check("rstmid_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstmid_m_trigger_off", m_trigger, 0);
      check("rstmid_idle", busy, 0);
      check("rstmid_op_rdy", op_rdy, 1);
      check("rstmid_h_op", h_op, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
